// File: rtl/connector_pkg.sv
// Shared channel definitions and the round-robin grant function
// used by the three-channel merge.
package connector_pkg;

    localparam int unsigned NUM_CH = 3;

    typedef logic [1:0] ch_id_t;

    // First requesting channel after 'last', wrapping 2->0.
    // Returns 'last' unchanged when nothing requests.
    function automatic ch_id_t next_rr(input ch_id_t last, input logic [2:0] req);
        ch_id_t c;
        ch_id_t g;
        logic   found;
        c     = last;
        g     = last;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
            if (!found && req[c]) begin
                g     = c;
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/connector_ch_fifo.sv
// Per-channel FIFO. 'push' must already be qualified by the caller;
// full is registered and tracks the post-edge occupancy.
module connector_ch_fifo #(
    parameter  int unsigned DATA_W     = 8,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned      AW      = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d   = (count_d == DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset: validity is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = full_q;
    assign count    = count_q;

endmodule

// File: rtl/connector_merge3.sv
// Merges three buffered write channels into one tagged valid/ready
// stream with round-robin arbitration and a load-blocking freeze.
module connector_merge3 #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        wen,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              freeze,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_ch,
    output logic [2:0]        full,
    output logic [2:0]        overflow
);

    import connector_pkg::*;

    localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] wdata    [NUM_CH];
    logic [DATA_W-1:0] pop_data [NUM_CH];
    logic [CNT_W-1:0]  count    [NUM_CH];
    logic [2:0]        empty;
    logic [2:0]        pop;
    logic [2:0]        accept;
    logic [2:0]        req;
    ch_id_t            grant;
    logic              load;
    logic [DATA_W-1:0] head_data;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    ch_id_t            out_ch_q, out_ch_d;
    ch_id_t            rr_last_q, rr_last_d;
    logic [2:0]        overflow_q, overflow_d;

    assign wdata[0] = data0;
    assign wdata[1] = data1;
    assign wdata[2] = data2;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // A write into a full FIFO still fits if the same channel pops this cycle.
        assign accept[i] = wen[i] && ((count[i] < DEPTH_C) || pop[i]);
        assign pop[i]    = load && (grant == ch_id_t'(i));

        connector_ch_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (accept[i]),
            .push_data (wdata[i]),
            .pop       (pop[i]),
            .pop_data  (pop_data[i]),
            .empty     (empty[i]),
            .full      (full[i]),
            .count     (count[i])
        );
    end

    always_comb begin
        req   = ~empty;
        grant = next_rr(rr_last_q, req);
        load  = !freeze && (!out_valid_q || out_ready) && (|req);
        case (grant)
            2'd0:    head_data = pop_data[0];
            2'd1:    head_data = pop_data[1];
            2'd2:    head_data = pop_data[2];
            default: head_data = '0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_last_d   = rr_last_q;
        overflow_d  = overflow_q | (wen & ~accept);
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = head_data;
            out_ch_d    = grant;
            rr_last_d   = grant;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_last_q   <= 2'd2;
            overflow_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_last_q   <= rr_last_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_connector_merge3.sv
// Directed bench for connector_merge3: latency, arbitration order,
// overflow, backpressure, freeze and mid-operation reset.
module tb_connector_merge3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] wen;
    logic [7:0] data0, data1, data2;
    logic       freeze;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_ch;
    logic [2:0] full;
    logic [2:0] overflow;

    int n_cmp = 0;
    int n_err = 0;

    connector_merge3 #(
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wen       (wen),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .freeze    (freeze),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".ch"},    32'(out_ch),    32'(c));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wen   = 3'b000;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wen = '0; data0 = '0; data1 = '0; data2 = '0;
        freeze = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_out("rst", 1'b0, 8'h00, 2'd0);
        chk("rst.full", 32'(full), 32'h0);
        chk("rst.ovf",  32'(overflow), 32'h0);

        // Single write: two-cycle latency, then idle
        wen = 3'b010; data1 = 8'hA5;
        tick();
        wen = 3'b000;
        chk("single.c1.valid", 32'(out_valid), 32'h0);
        tick();
        chk_out("single.c2", 1'b1, 8'hA5, 2'd1);
        tick();
        chk("single.c3.valid", 32'(out_valid), 32'h0);

        // Simultaneous writes after reset: channel 0 has first priority
        do_reset();
        wen = 3'b111; data0 = 8'h10; data1 = 8'h20; data2 = 8'h30;
        tick();
        wen = 3'b000;
        tick();
        chk_out("simul.w0", 1'b1, 8'h10, 2'd0);
        tick();
        chk_out("simul.w1", 1'b1, 8'h20, 2'd1);
        tick();
        chk_out("simul.w2", 1'b1, 8'h30, 2'd2);
        tick();
        chk("simul.idle", 32'(out_valid), 32'h0);

        // Overflow: 1 word in output reg + 4 in FIFO, sixth dropped
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            wen = 3'b010; data1 = 8'(k);
            tick();
            if (k == 5) begin
                chk("ovf.full5", 32'(full), 32'h2);
                chk("ovf.ovf5",  32'(overflow), 32'h0);
            end
        end
        wen = 3'b000;
        chk_out("ovf.hold", 1'b1, 8'h01, 2'd1);
        chk("ovf.full6", 32'(full), 32'h2);
        chk("ovf.ovf6",  32'(overflow), 32'h2);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk_out($sformatf("ovf.drain%0d", k), 1'b1, 8'(k), 2'd1);
            tick();
        end
        chk("ovf.drain.idle", 32'(out_valid), 32'h0);
        chk("ovf.sticky",     32'(overflow), 32'h2);
        chk("ovf.full.clr",   32'(full), 32'h0);

        // Backpressure: output held stable while not ready
        do_reset();
        out_ready = 1'b0;
        wen = 3'b001; data0 = 8'h10;
        tick();
        data0 = 8'h11;
        tick();
        wen = 3'b000;
        for (int k = 0; k < 3; k++) begin
            chk_out($sformatf("bp.hold%0d", k), 1'b1, 8'h10, 2'd0);
            tick();
        end
        chk_out("bp.hold3", 1'b1, 8'h10, 2'd0);
        out_ready = 1'b1;
        tick();
        chk_out("bp.next", 1'b1, 8'h11, 2'd0);
        tick();
        chk("bp.idle", 32'(out_valid), 32'h0);

        // Freeze: handoff completes, loads blocked, pushes continue
        do_reset();
        out_ready = 1'b0;
        wen = 3'b001; data0 = 8'h10;
        tick();
        wen = 3'b000;
        tick();
        chk_out("frz.pre", 1'b1, 8'h10, 2'd0);
        freeze = 1'b1; out_ready = 1'b1;
        wen = 3'b100; data2 = 8'hA1;
        tick();
        chk("frz.handoff", 32'(out_valid), 32'h0);
        data2 = 8'hA2;
        tick();
        chk("frz.blk1", 32'(out_valid), 32'h0);
        data2 = 8'hA3;
        tick();
        wen = 3'b000;
        chk("frz.blk2", 32'(out_valid), 32'h0);
        chk("frz.full", 32'(full), 32'h0);
        freeze = 1'b0;
        tick();
        chk_out("frz.r1", 1'b1, 8'hA1, 2'd2);
        tick();
        chk_out("frz.r2", 1'b1, 8'hA2, 2'd2);
        tick();
        chk_out("frz.r3", 1'b1, 8'hA3, 2'd2);
        tick();
        chk("frz.idle", 32'(out_valid), 32'h0);

        // Reset mid-operation with a full, overflowed channel 0
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wen = 3'b001; data0 = 8'hB1 + 8'(k);
            tick();
        end
        wen = 3'b000;
        chk_out("mid.pre", 1'b1, 8'hB1, 2'd0);
        chk("mid.pre.full", 32'(full), 32'h1);
        chk("mid.pre.ovf",  32'(overflow), 32'h1);
        reset = 1'b1; wen = 3'b100; data2 = 8'hEE;
        tick();
        reset = 1'b0; wen = 3'b000;
        chk_out("mid.rst", 1'b0, 8'h00, 2'd0);
        chk("mid.rst.full", 32'(full), 32'h0);
        chk("mid.rst.ovf",  32'(overflow), 32'h0);
        out_ready = 1'b1;
        tick();
        chk("mid.nostale", 32'(out_valid), 32'h0);
        wen = 3'b100; data2 = 8'hC7;
        tick();
        wen = 3'b000;
        tick();
        chk_out("mid.post", 1'b1, 8'hC7, 2'd2);
        tick();
        chk("mid.idle", 32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
